// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: instruction-type and error-code constants shared by the immediate encoder.
// Rev 1.0
`default_nettype none

package imm_encoder_pkg;

    localparam logic [2:0] TYPE_I = 3'b000;
    localparam logic [2:0] TYPE_S = 3'b010;
    localparam logic [2:0] TYPE_B = 3'b011;
    localparam logic [2:0] TYPE_J = 3'b100;
    localparam logic [2:0] TYPE_U = 3'b101;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_TYPE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // True when v[31:lsb] are all equal, i.e. v fits a signed field whose sign bit is lsb.
    function automatic logic sign_run(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] s;
        s = $signed(v) >>> lsb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_encoder_pack.sv
// imm_pack: places an immediate into the I/S/B/J/U bit positions of a skeleton word and checks it.
// Rev 1.0
`default_nettype none

module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  ins_type,
    input  logic [31:0] imm,
    input  logic [31:0] skeleton,
    output logic [31:0] instr,
    output logic [1:0]  chk_err
);

    logic [31:0] mask;
    logic [31:0] field;

    always_comb begin
        mask    = '0;
        field   = '0;
        chk_err = ERR_NONE;
        case (ins_type)
            TYPE_I: begin
                mask  = 32'hFFF0_0000;
                field = {imm[11:0], 20'b0};
                if (!sign_run(imm, 11)) chk_err = ERR_RANGE;
            end
            TYPE_S: begin
                mask  = 32'hFE00_0F80;
                field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                if (!sign_run(imm, 11)) chk_err = ERR_RANGE;
            end
            TYPE_B: begin
                mask  = 32'hFE00_0F80;
                field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                if (imm[0])                  chk_err = ERR_ALIGN;
                else if (!sign_run(imm, 12)) chk_err = ERR_RANGE;
            end
            TYPE_J: begin
                mask  = 32'hFFFF_F000;
                field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                if (imm[0])                  chk_err = ERR_ALIGN;
                else if (!sign_run(imm, 20)) chk_err = ERR_RANGE;
            end
            TYPE_U: begin
                mask  = 32'hFFFF_F000;
                field = {imm[31:12], 12'b0};
                if (imm[11:0] != 12'd0) chk_err = ERR_RANGE;
            end
            default: chk_err = ERR_TYPE;
        endcase
        instr = (skeleton & ~mask) | field;
    end

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// imm_encoder: encodes a burst of immediates into instruction words and streams them to memory.
// Rev 1.0
`default_nettype none

module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ins_type,
    input  logic [31:0]       imm,
    input  logic [31:0]       skeleton,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  err_index
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  total;
    logic [CNT_W-1:0]  accepted;
    logic [31:0]       instr;
    logic [1:0]        chk_err;
    logic              accept;
    logic              last;

    imm_pack u_pack (
        .ins_type (ins_type),
        .imm      (imm),
        .skeleton (skeleton),
        .instr    (instr),
        .chk_err  (chk_err)
    );

    assign accept = in_valid && in_ready;
    assign last   = (accepted + CNT_W'(1)) == total;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = (word_count == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = !wr_valid || wr_ready;
                if (in_valid && in_ready && (chk_err != ERR_NONE || last))
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!wr_valid || wr_ready) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr      <= '0;
            total     <= '0;
            accepted  <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_index <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                addr      <= start_addr & ~ADDR_W'(3);
                total     <= word_count;
                accepted  <= '0;
                err       <= 1'b0;
                err_code  <= ERR_NONE;
                err_index <= '0;
            end
            if (wr_valid && wr_ready) wr_valid <= 1'b0;
            // A bad entry is consumed but never reaches the output register.
            if (accept) begin
                accepted <= accepted + CNT_W'(1);
                if (chk_err == ERR_NONE) begin
                    wr_valid <= 1'b1;
                    wr_data  <= instr;
                    wr_addr  <= addr;
                    addr     <= addr + ADDR_W'(4);
                end else begin
                    err       <= 1'b1;
                    err_code  <= chk_err;
                    err_index <= accepted;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate sign-extension stage: takes a 32-bit immediate plus an instruction "skeleton" word and packs the immediate into the RISC-V I/S/B/J/U bit positions.
- Checks immediate range and alignment, then streams the finished instruction words into instruction memory at auto-incrementing addresses.
- Used by the test-program loader and the self-check path to build program images on chip.
- Runs one burst of N words per start pulse and reports completion or the first encoding error.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width.
- CNT_W, 8, width of the word counter; a burst holds 1..2^CNT_W-1 words.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a burst; honoured only in IDLE.
- start_addr  in  ADDR_W  byte address of the first word; bits [1:0] are ignored and treated as 0.
- word_count  in  CNT_W  number of words in the burst; 0 means complete immediately.
- in_valid  in  1  input entry valid.
- in_ready  out  1  entry accepted when in_valid && in_ready.
- ins_type  in  3  000=I, 010=S, 011=B, 100=J, 101=U; any other code is illegal.
- imm  in  32  immediate value, two's complement.
- skeleton  in  32  opcode/rd/rs/funct bits; bits in immediate positions are masked off.
- wr_valid  out  1  memory write request.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  ADDR_W  write byte address.
- wr_data  out  32  encoded instruction word.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at the end of a burst.
- err  out  1  sticky until the next start: the burst aborted.
- err_code  out  2  01=range, 10=misaligned, 11=illegal type.
- err_index  out  CNT_W  zero-based index of the offending entry.

Behaviour:
- Reset values: in_ready=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, err_code=0, err_index=0. The FSM returns to IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, latch address and count, clear err/err_code/err_index. Go to RUN, or to DONE if word_count=0.
  - RUN: in_ready = !wr_valid || wr_ready. Each accepted entry is encoded combinationally and registered into wr_data/wr_addr in the same cycle, so wr_valid rises the next cycle (latency 1). Address advances by 4 per accepted word and wraps mod 2^ADDR_W. The accepted count increments per acceptance. When the last entry is accepted, go to DRAIN.
  - DRAIN: in_ready=0. Hold wr_valid/wr_addr/wr_data stable until wr_ready, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Encoding: instr = (skeleton & ~mask) | field. Field placement by type:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
- Checks, evaluated in priority order illegal > misaligned > range:
  - I/S: imm[31:11] must be all equal.
  - B: imm[0]=0 and imm[31:12] all equal.
  - J: imm[0]=0 and imm[31:20] all equal.
  - U: imm[11:0]=0; a violation reports code 01.
- Error handling: an entry that fails a check is consumed (in_ready was high) but not written. err, err_code and err_index (the accepted count) are set, and the FSM goes to DRAIN. Any previously registered good word still completes its write.
- Backpressure: wr_data/wr_addr must not change while wr_valid && !wr_ready.
- Outside IDLE, start is ignored. in_valid outside RUN is ignored and in_ready stays 0.
- Reset asserted mid-burst: immediate abort with all outputs at reset values. No done pulse.

Decomposition:
- Shared package holds the ins_type localparams (I/S/B/J/U) and the err_code localparams; the immediate decoder uses the same type constants.
- Natural sub-module: imm_pack, purely combinational. Inputs ins_type, imm, skeleton; outputs instr[31:0] and chk_err[1:0]. The top handles the FSM, counters and output register.

Test Plan:
- I/U burst: start_addr=0x10, count=2.
  - I, skel=0x00000013, imm=0xFFFFFFFF -> wr_data=0xFFF00013 @0x10.
  - U, skel=0x000000B7, imm=0x12345000 -> 0x123450B7 @0x14.
  - done pulses once after the last write.
- B/J encoding:
  - B, skel=0x00000063, imm=8 -> 0x00000463.
  - J, skel=0x0000006F, imm=0xFFFFFFFC -> 0xFFDFF06F.
- Errors:
  - Entry 1 of 3 is I with imm=2048 -> err=1, err_code=01, err_index=1; only entry 0 is written; done pulses.
  - B with imm=3 -> err_code=10.
  - ins_type=001 -> err_code=11.
- Backpressure: hold wr_ready=0 for 5 cycles mid-burst -> in_ready=0, wr_data/wr_addr stable, no entry lost or duplicated.
- Boundaries:
  - word_count=0 -> done the cycle after start, no writes.
  - start_addr=2^ADDR_W-4, count=2 -> second write goes to 0x0.
- Reset asserted in RUN after 1 of 4 writes -> all outputs 0, no done pulse. A new start then works normally.
